bus_responder: RTL

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/i8085_bus_pkg.sv | 28 ++
 rtl/bus_responder_if.sv | 25 ++
 rtl/resp_mem.sv | 20 ++
 rtl/bus_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/i8085_bus_pkg.sv
// Shared types for the 8085-style bus responder: bus status codes,
// responder FSM states and the I/O port count.
package i8085_bus_pkg;

   localparam int IO_PORTS = 4;

   // S1:S0 as driven by the CPU
   typedef enum logic [1:0] {
      HALT  = 2'b00,
      WRITE = 2'b01,
      READ  = 2'b10,
      FETCH = 2'b11
   } bus_status_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LATCHED = 3'd1,
      WAIT    = 3'd2,
      ACK     = 3'd3,
      HOLD    = 3'd4
   } bus_state_e;

   // Opcode fetch is a read as far as the responder is concerned
   function automatic logic is_read(input bus_status_e s);
      return (s == READ) || (s == FETCH);
   endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-side bus bundle. The CPU (or a bench) is the master, the responder
// is the slave.
interface bus_responder_if;
   logic       ALE;
   logic       S1;
   logic       S0;
   logic       IO_Mn;
   logic       RDn;
   logic       WRn;
   logic [7:0] ADD;
   logic [7:0] DATA_in;
   logic [7:0] DATA_out;
   logic       DATA_oe;
   logic       READY;

   modport master (
      output ALE, S1, S0, IO_Mn, RDn, WRn, ADD, DATA_in,
      input  DATA_out, DATA_oe, READY
   );

   modport slave (
      input  ALE, S1, S0, IO_Mn, RDn, WRn, ADD, DATA_in,
      output DATA_out, DATA_oe, READY
   );
endinterface

// File: rtl/resp_mem.sv
// 256x8 responder storage: synchronous write, combinational read.
// Deliberately has no reset so contents survive a bus reset.
module resp_mem (
   input  logic       clk,
   input  logic       we_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o
);

   logic [7:0] mem [256];

   // single write port, addressed by the latched bus address
   always_ff @(posedge clk) begin
      if (we_i) mem[addr_i] <= wdata_i;
   end

   assign rdata_o = mem[addr_i];

endmodule

// File: rtl/bus_responder.sv
// 8085-style bus responder: latches address/status on ALE, inserts a fixed
// number of wait states, serves reads from memory or four input ports and
// commits writes to memory or four output latches once per bus cycle.
module bus_responder
   import i8085_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [7:0]  IO_BASE     = 8'h00
) (
   input  logic           clk,
   input  logic           rst,
   bus_responder_if.slave bus,
   input  logic [31:0]    io_in,
   output logic [31:0]    io_out,
   output logic           err
);

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   bus_state_e                     state_q;
   bus_status_e                    stat_q;
   logic [7:0]                     addr_q;
   logic                           iom_q;
   logic [2:0]                     cnt_q;
   logic [7:0]                     dout_q;
   logic                           oe_q;
   logic                           ready_q;
   logic                           err_q;
   logic [IO_PORTS-1:0][7:0]       io_q;

   logic [IO_PORTS-1:0][7:0]       io_in_v;
   logic [7:0]                     mem_rdata;
   logic [7:0]                     rd_data_d;
   logic                           io_hit;
   logic [1:0]                     port_sel;
   logic                           rd_lo;
   logic                           wr_lo;
   logic                           strobe_err;
   logic                           strobe_ok;
   logic                           commit;
   logic                           mem_we;
   logic [IO_PORTS-1:0]            io_we;

   assign io_in_v  = io_in;
   assign io_hit   = (addr_q[7:2] == IO_BASE[7:2]);
   assign port_sel = addr_q[1:0];
   assign rd_lo    = ~bus.RDn;
   assign wr_lo    = ~bus.WRn;

   // Both strobes low, or a strobe that contradicts the latched status
   assign strobe_err = (rd_lo && wr_lo) ||
                       (rd_lo && !is_read(stat_q)) ||
                       (wr_lo && (stat_q != WRITE));
   assign strobe_ok  = (rd_lo || wr_lo) && !strobe_err;

   // Write lands on the edge leaving ACK; a new ALE on that edge drops it
   assign commit = (state_q == ACK) && (stat_q == WRITE) && !bus.ALE;
   assign mem_we = commit && !iom_q;

   // read data mux: memory, matched input port, or open-bus 8'hFF
   always_comb begin
      rd_data_d = mem_rdata;
      if (iom_q) rd_data_d = io_hit ? io_in_v[port_sel] : 8'hFF;
   end

   // one-hot output-latch write enables; unmatched I/O writes vanish here
   always_comb begin
      io_we = '0;
      for (int k = 0; k < IO_PORTS; k++)
         io_we[k] = commit && iom_q && io_hit && (port_sel == 2'(k));
   end

   resp_mem u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (addr_q),
      .wdata_i (bus.DATA_in),
      .rdata_o (mem_rdata)
   );

   // bus-cycle FSM; READY, DATA_out, DATA_oe and err are all registered here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         stat_q  <= HALT;
         addr_q  <= 8'h00;
         iom_q   <= 1'b0;
         cnt_q   <= 3'd0;
         dout_q  <= 8'h00;
         oe_q    <= 1'b0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (bus.ALE) begin
            // ALE always starts a fresh cycle, whatever was in flight
            ready_q <= 1'b1;
            oe_q    <= 1'b0;
            cnt_q   <= 3'd0;
            if (bus_status_e'({bus.S1, bus.S0}) == HALT) begin
               state_q <= IDLE;
            end else begin
               state_q <= LATCHED;
               addr_q  <= bus.ADD;
               stat_q  <= bus_status_e'({bus.S1, bus.S0});
               iom_q   <= bus.IO_Mn;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  // stray strobes without a preceding ALE are ignored
               end
               LATCHED: begin
                  if (strobe_err) begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end else if (strobe_ok) begin
                     if (WS == 3'd0) begin
                        state_q <= ACK;
                        if (is_read(stat_q)) begin
                           dout_q <= rd_data_d;
                           oe_q   <= 1'b1;
                        end
                     end else begin
                        state_q <= WAIT;
                        cnt_q   <= WS;
                        ready_q <= 1'b0;
                     end
                  end
               end
               WAIT: begin
                  if (cnt_q <= 3'd1) begin
                     state_q <= ACK;
                     cnt_q   <= 3'd0;
                     ready_q <= 1'b1;
                     if (is_read(stat_q)) begin
                        dout_q <= rd_data_d;
                        oe_q   <= rd_lo;
                     end
                  end else begin
                     cnt_q <= cnt_q - 3'd1;
                  end
               end
               ACK: begin
                  state_q <= HOLD;
                  if (!rd_lo) oe_q <= 1'b0;
               end
               HOLD: begin
                  if (!rd_lo) oe_q <= 1'b0;
                  if (!rd_lo && !wr_lo) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // output latches, reset with the bus
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_q <= '0;
      end else begin
         for (int k = 0; k < IO_PORTS; k++)
            if (io_we[k]) io_q[k] <= bus.DATA_in;
      end
   end

   assign io_out       = io_q;
   assign err          = err_q;
   assign bus.DATA_out = dout_q;
   assign bus.DATA_oe  = oe_q;
   assign bus.READY    = ready_q;

endmodule
